// File: rtl/signature_accumulator.sv
// Signature analyser: drives a stimulus count and folds observed buses into a rotating-add signature.
// Optional mid-run snapshot register is compiled in with `define SIG_SNAPSHOT_EN.
module signature_accumulator #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 12,
    parameter int STIM_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DATA_W-1:0]        seed,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [STIM_W-1:0]        snap_point,
    output logic [STIM_W-1:0]        stimulus,
    output logic [2*DATA_W-1:0]      signature,
    output logic [2*DATA_W-1:0]      snap_sig,
    output logic                     busy,
    output logic                     done
);

    localparam int SW = 2 * DATA_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [STIM_W-1:0] r_stim;
    logic [SW-1:0]     r_sig;
    logic [DATA_W-1:0] r_seed;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] w_scr;
    logic [DATA_W-1:0] w_sum;
    logic [SW-1:0]     w_fold;
    logic              w_last;
    logic              w_fold_en;

    always_comb begin
        w_scr = r_seed;
        for (int k = 0; k < NUM_CH; k++) begin
            w_scr = w_scr ^ ch_data[k*DATA_W +: DATA_W];
        end
    end

    // Carry out of the low-half add is dropped, then the whole word rotates left by one.
    assign w_sum     = r_sig[DATA_W-1:0] + w_scr;
    assign w_fold    = {r_sig[SW-2:DATA_W], w_sum, r_sig[SW-1]};
    assign w_last    = &r_stim;
    assign w_fold_en = (r_state == S_RUN) && !start && !abort && !w_last;

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_RUN;
        end else if (r_state == S_RUN) begin
            if (abort) begin
                w_next = S_IDLE;
            end else if (w_last) begin
                w_next = S_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_stim  <= '0;
            r_sig   <= '0;
            r_seed  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
            if (start) begin
                r_stim <= '0;
                r_sig  <= '0;
                r_seed <= seed;
            end else if (w_fold_en) begin
                r_stim <= r_stim + 1'b1;
                r_sig  <= w_fold;
            end
        end
    end

`ifdef SIG_SNAPSHOT_EN
    logic [SW-1:0] r_snap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap <= '0;
        end else if (start) begin
            r_snap <= '0;
        end else if (w_fold_en && (r_stim == snap_point)) begin
            r_snap <= w_fold;
        end
    end

    assign snap_sig = r_snap;
`else
    logic w_unused_snap;

    assign w_unused_snap = ^snap_point;
    assign snap_sig      = '0;
`endif

    assign stimulus  = r_stim;
    assign signature = r_sig;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_signature_accumulator.sv
// Randomized scoreboard bench for signature_accumulator (3 channels, 4-bit stimulus).
// Snapshot expectations follow SIG_SNAPSHOT_EN as compiled.
module tb_signature_accumulator;

    localparam int DW = 8;
    localparam int NC = 3;
    localparam int STW = 4;
    localparam int NFOLD = (1 << STW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [DW-1:0]     seed;
    logic [NC*DW-1:0]  ch_data;
    logic [STW-1:0]    snap_point;
    logic [STW-1:0]    stimulus;
    logic [2*DW-1:0]   signature;
    logic [2*DW-1:0]   snap_sig;
    logic              busy;
    logic              done;

    signature_accumulator #(.DATA_W(DW), .NUM_CH(NC), .STIM_W(STW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .seed(seed), .ch_data(ch_data), .snap_point(snap_point),
        .stimulus(stimulus), .signature(signature), .snap_sig(snap_sig),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [STW-1:0]  stim;
        logic [2*DW-1:0] sig;
    } exp_t;

    typedef struct packed {
        logic [2*DW-1:0] sig;
        logic [2*DW-1:0] snap;
    } fin_t;

    exp_t q[$];
    fin_t fq[$];
    int   passed = 0;
    int   total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: add scramble into the low byte mod 256, then rotate 16-bit word left by one.
    function automatic logic [15:0] model_fold(input logic [15:0] s, input logic [7:0] scr);
        int lo;
        int word;
        lo = (int'(s[7:0]) + int'(scr)) % 256;
        word = (int'(s[15:8]) * 256) + lo;
        word = ((word * 2) % 65536) + (word / 32768);
        return word[15:0];
    endfunction

    // Monitor: each new stimulus value in RUN is one fold; each done rise is a finished run.
    logic [STW-1:0] prev_stim = '0;
    logic           prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        fin_t f;
        if (!reset && busy && stimulus != 0 && stimulus != prev_stim) begin
            if (q.size() == 0) begin
                check("fold_unexpected", {28'd0, stimulus}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                check("fold_stim", {28'd0, stimulus}, {28'd0, e.stim});
                check("fold_sig", {16'd0, signature}, {16'd0, e.sig});
            end
        end
        if (done && !prev_done) begin
            if (fq.size() == 0) begin
                check("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
                f = fq.pop_front();
                check("final_sig", {16'd0, signature}, {16'd0, f.sig});
                check("final_snap", {16'd0, snap_sig}, {16'd0, f.snap});
            end
        end
        prev_stim = stimulus;
        prev_done = done;
    end

    // mode 0: full run, 1: abort at fold stop_at, 2: async reset before fold stop_at
    task automatic run(input logic [7:0] sd, input bit zero_ch, input int mode, input int stop_at);
        logic [31:0] c;
        logic [7:0]  scr;
        logic [15:0] m;
        logic [15:0] snapm;
        fin_t        f;
        @(posedge clk); #1;
        q.delete();
        fq.delete();
        start = 1'b1;
        seed = sd;
        snap_point = STW'($urandom_range(0, NFOLD));
        @(posedge clk); #1;
        start = 1'b0;
        check("start_stim", {28'd0, stimulus}, 32'd0);
        check("start_sig", {16'd0, signature}, 32'd0);
        check("start_busy", {31'd0, busy}, 32'd1);
        m = '0;
        snapm = '0;
        for (int k = 1; k <= NFOLD; k++) begin
            c = zero_ch ? 32'd0 : $urandom;
            ch_data = c[NC*DW-1:0];
            if (mode == 1 && k == stop_at) begin
                abort = 1'b1;
                @(posedge clk); #1;
                abort = 1'b0;
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_done", {31'd0, done}, 32'd0);
                check("abort_stim", {28'd0, stimulus}, k - 1);
                check("abort_sig", {16'd0, signature}, {16'd0, m});
                return;
            end
            if (mode == 2 && k == stop_at) begin
                reset = 1'b1;
                #2;
                check("rst_stim", {28'd0, stimulus}, 32'd0);
                check("rst_sig", {16'd0, signature}, 32'd0);
                check("rst_snap", {16'd0, snap_sig}, 32'd0);
                check("rst_busy", {31'd0, busy}, 32'd0);
                check("rst_done", {31'd0, done}, 32'd0);
                #1;
                reset = 1'b0;
                @(posedge clk); #1;
                check("rst_stays_idle", {31'd0, busy}, 32'd0);
                return;
            end
            scr = sd ^ c[7:0] ^ c[15:8] ^ c[23:16];
            m = model_fold(m, scr);
            if (k - 1 == int'(snap_point)) snapm = m;
            q.push_back(exp_t'{stim: STW'(k), sig: m});
            @(posedge clk); #1;
        end
        check("pre_done", {31'd0, done}, 32'd0);
        f.sig = m;
`ifdef SIG_SNAPSHOT_EN
        f.snap = snapm;
`else
        f.snap = '0;
`endif
        fq.push_back(f);
        ch_data = $urandom;
        @(posedge clk); #1;
        check("done_edge", {31'd0, done}, 32'd1);
        check("done_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("fold_q_drained", q.size(), 32'd0);
        check("final_q_drained", fq.size(), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        seed = '0;
        ch_data = '0;
        snap_point = '0;
        #12;
        check("reset_stim", {28'd0, stimulus}, 32'd0);
        check("reset_sig", {16'd0, signature}, 32'd0);
        check("reset_snap", {16'd0, snap_sig}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        reset = 1'b0;

        run(8'h01, 1'b1, 0, 0);
        check("seed01_final", {16'd0, signature}, 32'h0000_FFFE);

        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_in_done", {31'd0, done}, 32'd1);
        check("hold_sig", {16'd0, signature}, 32'h0000_FFFE);
        check("hold_stim", {28'd0, stimulus}, 32'd15);

        run(8'hFF, 1'b1, 0, 0);
        for (int r = 0; r < 3; r++) run(8'($urandom), 1'b0, 0, 0);

        run(8'($urandom), 1'b0, 1, 9);
        repeat (2) @(posedge clk);
        #1;
        check("idle_hold_stim", {28'd0, stimulus}, 32'd8);

        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_data = $urandom;
            seed = 8'($urandom);
            @(posedge clk); #1;
        end
        check("held_start_stim", {28'd0, stimulus}, 32'd0);
        check("held_start_sig", {16'd0, signature}, 32'd0);
        run(8'($urandom), 1'b0, 0, 0);

        run(8'($urandom), 1'b0, 2, 7);
        run(8'($urandom), 1'b0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
